// File: rtl/mtimer.sv
// ============================================================================
// Module   : mtimer
// Purpose  : Memory-mapped machine timer (64-bit mtime/mtimecmp, prescaler,
//            level timer interrupt) behind a one-cycle data-bus slave port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_be,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic        bus_ready,
    input  logic        halted,
    input  logic        stopcount,
    output logic        timer
);

    localparam logic [2:0] c_mtime_lo = 3'd0;
    localparam logic [2:0] c_mtime_hi = 3'd1;
    localparam logic [2:0] c_cmp_lo   = 3'd2;
    localparam logic [2:0] c_cmp_hi   = 3'd3;
    localparam logic [2:0] c_ctrl     = 3'd4;
    localparam logic [2:0] c_presc    = 3'd5;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_en;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;

    logic [31:0] w_offs;
    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_rd;
    logic        w_count_en;
    logic        w_tick;
    logic        w_presc_clr;
    logic [63:0] w_mtime_next;
    logic [63:0] w_mtimecmp_next;
    logic [31:0] w_rdata;

    // Offset subtraction plus lower bound keeps the decode correct for any base.
    assign w_offs  = bus_addr - BASE_ADDR;
    assign bus_hit = (bus_addr >= BASE_ADDR) && (w_offs < 32'd32);
    assign w_idx   = w_offs[4:2];

    assign w_wr = bus_write && bus_hit;
    assign w_rd = bus_read && !bus_write && bus_hit;

    assign w_count_en  = r_en && !(halted && stopcount);
    assign w_tick      = w_count_en && (r_presc_cnt == r_presc);
    assign w_presc_clr = w_wr && ((w_idx == c_ctrl) || (w_idx == c_presc));

    // A bus write to an mtime word overrides a coincident tick.
    always_comb begin
        w_mtime_next = r_mtime;
        if (w_wr && (w_idx == c_mtime_lo))
            w_mtime_next[31:0] = merge_be(r_mtime[31:0], bus_wdata, bus_be);
        else if (w_wr && (w_idx == c_mtime_hi))
            w_mtime_next[63:32] = merge_be(r_mtime[63:32], bus_wdata, bus_be);
        else if (w_tick)
            w_mtime_next = r_mtime + 64'd1;
    end

    always_comb begin
        w_mtimecmp_next = r_mtimecmp;
        if (w_wr && (w_idx == c_cmp_lo))
            w_mtimecmp_next[31:0] = merge_be(r_mtimecmp[31:0], bus_wdata, bus_be);
        else if (w_wr && (w_idx == c_cmp_hi))
            w_mtimecmp_next[63:32] = merge_be(r_mtimecmp[63:32], bus_wdata, bus_be);
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            c_mtime_lo: w_rdata = r_mtime[31:0];
            c_mtime_hi: w_rdata = r_mtime[63:32];
            c_cmp_lo:   w_rdata = r_mtimecmp[31:0];
            c_cmp_hi:   w_rdata = r_mtimecmp[63:32];
            c_ctrl:     w_rdata = {31'd0, r_en};
            c_presc:    w_rdata = 32'(r_presc);
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtime     <= 64'd0;
            r_mtimecmp  <= {64{1'b1}};
            r_en        <= 1'b1;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            timer       <= 1'b0;
            bus_ready   <= 1'b0;
            bus_rdata   <= 32'd0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            timer      <= (w_mtime_next >= w_mtimecmp_next);

            if (w_wr && (w_idx == c_ctrl) && bus_be[0])
                r_en <= bus_wdata[0];
            if (w_wr && (w_idx == c_presc))
                r_presc <= PRESC_W'(merge_be(32'(r_presc), bus_wdata, bus_be));

            if (w_presc_clr)
                r_presc_cnt <= '0;
            else if (w_count_en)
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);

            bus_ready <= w_wr || w_rd;
            if (w_rd)
                bus_rdata <= w_rdata;
        end
    end

endmodule

`default_nettype wire
